// File: rtl/and3_exerciser.sv
// Walks {A,B,C} through 000..111 into a 3-input AND gate, holding each vector SETTLE_CYCLES+1 cycles and checking Y on the last.
// A run takes 8*(SETTLE_CYCLES+1) busy cycles plus one DONE cycle; START is only accepted in IDLE.
module and3_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             Y,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VLD,
  output logic [2:0]       FAIL_VEC
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FIN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       mismatch;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Gate inputs and status are decoded from state so an async reset clears them immediately.
  always_comb begin
    state_nxt = state;
    A         = 1'b0;
    B         = 1'b0;
    C         = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) state_nxt = SETTLE;
      end
      SETTLE: begin
        {A, B, C} = vec;
        BUSY      = 1'b1;
        if (cnt == CNT_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        {A, B, C} = vec;
        BUSY      = 1'b1;
        state_nxt = (vec == 3'd7) ? FIN : SETTLE;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mismatch = (Y != (&vec));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vec      <= 3'd0;
      cnt      <= 4'd0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_VLD <= 1'b0;
      FAIL_VEC <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            vec      <= 3'd0;
            cnt      <= 4'd0;
            PASS     <= 1'b0;
            ERR_CNT  <= '0;
            FAIL_VLD <= 1'b0;
            FAIL_VEC <= 3'd0;
          end
        end
        SETTLE: cnt <= cnt + 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_W'(1);
            if (!FAIL_VLD) begin
              FAIL_VLD <= 1'b1;
              FAIL_VEC <= vec;
            end
          end
          // FAIL_VLD still reflects only earlier vectors here, so fold in the current compare.
          if (vec == 3'd7) begin
            PASS <= !FAIL_VLD && !mismatch;
          end else begin
            vec <= vec + 3'd1;
            cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
